// File: rtl/rv_pkg.sv
// Shared constants for the RV32I ADDI datapath slice: widths, opcode/funct3
// encodings for ADDI, and the default reset PC.
package rv_pkg;

    localparam int unsigned RV_XLEN     = 32;
    localparam int unsigned RV_REG_AW   = 5;
    localparam int unsigned RV_NUM_REGS = 32;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_ADDI    = 3'b000;

    localparam logic [RV_XLEN-1:0] RV_RESET_PC = 32'h8000_0000;

endpackage : rv_pkg

// File: rtl/rv_regfile.sv
// 32 x XLEN register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero, asynchronous active-low clear.
// Ports:
//   clk, rst_n            clock and async active-low clear
//   raddr1_i / rdata1_o   read port 1 (combinational)
//   raddr2_i / rdata2_o   read port 2 (combinational)
//   we_i, waddr_i, wdata_i  write port, captured on rising clk
// A read of the register being written in the same cycle returns the old value.
module rv_regfile
    import rv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [RV_REG_AW-1:0] raddr1_i,
    output logic [RV_XLEN-1:0]   rdata1_o,
    input  logic [RV_REG_AW-1:0] raddr2_i,
    output logic [RV_XLEN-1:0]   rdata2_o,
    input  logic                 we_i,
    input  logic [RV_REG_AW-1:0] waddr_i,
    input  logic [RV_XLEN-1:0]   wdata_i
);

    // x0 has no storage; index 0 is never written and reads as zero.
    logic [RV_XLEN-1:0] regs_q [1:RV_NUM_REGS-1];

    // Write port with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < int'(RV_NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports.
    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (raddr1_i != '0) begin
            rdata1_o = regs_q[raddr1_i];
        end
        if (raddr2_i != '0) begin
            rdata2_o = regs_q[raddr2_i];
        end
    end

endmodule : rv_regfile

// File: rtl/rv_addi_datapath.sv
// Single-cycle RV32I datapath slice executing ADDI: PC register, field decode,
// register file and adder. The host supplies the instruction word each cycle.
// Ports:
//   clk, rst_n  rising-edge clock, async active-low reset
//   inst        instruction word for the current PC
//   pc          current program counter (registered)
//   src1, src2  register file values of rs1 = inst[19:15], rs2 = inst[24:20]
//   rd          destination field inst[11:7]
//   imm         sign-extended I-type immediate inst[31:20]
//   sum         src1 + imm
module rv_addi_datapath
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RV_RESET_PC,
    parameter int unsigned XLEN     = RV_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] src1,
    output logic [XLEN-1:0] src2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] sum
);

    logic [XLEN-1:0]      pc_q;
    logic [XLEN-1:0]      pc_d;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [RV_REG_AW-1:0] rs1;
    logic [RV_REG_AW-1:0] rs2;
    logic                 wr_en;

    // PC: free-running +4, wraps modulo 2^XLEN.
    always_comb begin
        pc_d = pc_q + XLEN'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= XLEN'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    // Field decode, applied to every encoding.
    always_comb begin
        opcode = inst[6:0];
        funct3 = inst[14:12];
        rs1    = inst[19:15];
        rs2    = inst[24:20];
        rd     = inst[11:7];
        imm    = {{(XLEN-12){inst[31]}}, inst[31:20]};
    end

    // Only ADDI writes back; rd == 0 is filtered here and again in the regfile.
    always_comb begin
        wr_en = (opcode == OPC_OP_IMM) && (funct3 == F3_ADDI) && (rd != 5'd0);
    end

    rv_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1_i (rs1),
        .rdata1_o (src1),
        .raddr2_i (rs2),
        .rdata2_o (src2),
        .we_i     (wr_en),
        .waddr_i  (rd),
        .wdata_i  (sum)
    );

    // ALU: plain modulo add, no flags.
    always_comb begin
        sum = src1 + imm;
    end

    assign pc = pc_q;

endmodule : rv_addi_datapath

// File: tb/tb_rv_addi_datapath.sv
module tb_rv_addi_datapath;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [31:0] pc, src1, src2, imm, sum;
    logic [4:0]  rd;

    logic [31:0] inst_w;
    logic [31:0] pc_w, src1_w, src2_w, imm_w, sum_w;
    logic [4:0]  rd_w;

    int checks;
    int failures;

    // Reference state
    logic [31:0] m_pc;
    logic [31:0] m_rf [0:31];

    rv_addi_datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .inst  (inst),
        .pc    (pc),
        .src1  (src1),
        .src2  (src2),
        .rd    (rd),
        .imm   (imm),
        .sum   (sum)
    );

    rv_addi_datapath #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .inst  (inst_w),
        .pc    (pc_w),
        .src1  (src1_w),
        .src2  (src2_w),
        .rd    (rd_w),
        .imm   (imm_w),
        .sum   (sum_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h8000_0000;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    endtask

    function automatic logic [31:0] f_imm(input logic [31:0] ins);
        logic [31:0] v;
        v = ins >> 20;
        if (v >= 32'd2048) v = v - 32'd4096;
        return v;
    endfunction

    // Compare all outputs with the model, clock once, advance the model.
    task automatic step(input logic [31:0] ins);
        int r1, r2, d, op, f3;
        logic [31:0] e_sum;
        inst = ins;
        #1;
        op = int'(ins % 128);
        d  = int'((ins >> 7) % 32);
        f3 = int'((ins >> 12) % 8);
        r1 = int'((ins >> 15) % 32);
        r2 = int'((ins >> 20) % 32);
        e_sum = m_rf[r1] + f_imm(ins);
        check("pc",   pc,   m_pc);
        check("rd",   {27'd0, rd}, 32'(d));
        check("imm",  imm,  f_imm(ins));
        check("src1", src1, m_rf[r1]);
        check("src2", src2, m_rf[r2]);
        check("sum",  sum,  e_sum);
        @(posedge clk);
        m_pc = m_pc + 32'd4;
        if (op == 19 && f3 == 0 && d != 0) m_rf[d] = e_sum;
        #1;
    endtask

    function automatic logic [31:0] rand_addi();
        logic [31:0] v;
        v = $urandom;
        return {v[31:20], 5'($urandom_range(0, 7)), 3'b000, 5'($urandom_range(0, 7)), 7'b0010011};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        inst     = 32'd0;
        inst_w   = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", pc, 32'h8000_0000);
        check("reset_pc_wrap", pc_w, 32'hFFFF_FFF8);
        rst_n = 1'b1;

        // PC progression and modulo wrap on the second instance
        for (int i = 0; i < 3; i++) begin
            check("wrap_pc", pc_w, 32'hFFFF_FFF8 + 32'(4 * i));
            step(32'h0000_0000);
        end
        check("wrap_pc_zero", pc_w, 32'h0000_0004);
        check("pc_after3", pc, 32'h8000_000C);

        // addi x3,x0,-3 then addi x4,x3,5
        inst = 32'hFFD0_0193; #1;
        check("d_rd3", {27'd0, rd}, 32'd3);
        check("d_imm_m3", imm, 32'hFFFF_FFFD);
        check("d_sum_m3", sum, 32'hFFFF_FFFD);
        step(32'hFFD0_0193);
        inst = 32'h0051_8213; #1;
        check("d_src1_x3", src1, 32'hFFFF_FFFD);
        check("d_sum_2", sum, 32'h0000_0002);
        step(32'h0051_8213);

        // write to x0 is ignored
        inst = 32'h0050_0013; #1;
        check("d_sum_5", sum, 32'd5);
        step(32'h0050_0013);
        inst = 32'h0000_0093; #1;
        check("d_x0_zero", src1, 32'd0);
        step(32'h0000_0093);

        // non-ADDI encodings do not write
        step(32'h0070_0293);
        step(32'h0000_02B3);
        inst = 32'h0002_8313; #1;
        check("d_x5_kept", src1, 32'd7);
        step(32'h0002_8313);

        // randomized run
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 1) == 0) ? rand_addi() : $urandom);
        end

        // mid-run reset between edges
        step(32'hFFD0_0193);
        inst  = 32'h0001_8213;
        #1;
        check("pre_reset_x3", src1, 32'hFFFF_FFFD);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset_pc", pc, 32'h8000_0000);
        check("midreset_x3", src1, 32'd0);
        rst_n = 1'b1;
        #1;
        step(32'h0001_8213);
        for (int i = 0; i < 50; i++) begin
            step(rand_addi());
        end

        // reset held across an edge carrying an ADDI: write is discarded
        inst  = 32'h0010_0193;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        inst  = 32'h0001_8213;
        #1;
        check("reset_edge_nowrite", src1, 32'd0);
        step(32'h0001_8213);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rv_addi_datapath

// File: doc/rv_addi_datapath.md
Name: rv_addi_datapath

Overview:
- Minimal single-cycle RV32I datapath slice: PC register, instruction field decoder, 32x32 register file, and adder ALU executing ADDI.
- The instruction word arrives from the simulation host (C side) each cycle. The block exposes PC, decoded fields, operands and the ALU result for host-side checking.
- Sits at the top of the NPC core, below the simulation wrapper.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, datapath width (fixed at 32; not required to work otherwise).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- inst  input  32  instruction word for the current PC, valid throughout the cycle
- pc  output  32  current program counter (registered)
- src1  output  32  register file value of rs1 = inst[19:15]
- src2  output  32  register file value of rs2 = inst[24:20]
- rd  output  5  destination field inst[11:7]
- imm  output  32  I-type immediate, sign-extended inst[31:20]
- sum  output  32  ALU result src1 + imm

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-to-clk release):
  - pc = RESET_PC.
  - All registers x1..x31 = 0.
  - Combinational outputs follow inst and the cleared register file.
- PC:
  - pc <= pc + 4 on every rising clk edge when not in reset.
  - Modulo 2^32 wrap (32'hFFFF_FFFC -> 32'h0000_0000).
  - No branches or stalls.
- Decode (purely combinational, zero latency from inst):
  - rd = inst[11:7].
  - imm = {{20{inst[31]}}, inst[31:20]}.
  - Fields are decoded for every opcode, regardless of validity.
- Register file:
  - Two combinational read ports. x0 always reads 0.
  - One synchronous write port.
  - Read-during-write returns the old value; the new value is visible from the next cycle.
- ALU:
  - sum = src1 + imm, combinational, modulo 2^32, no overflow flag.
- Writeback:
  - Write enable = (inst[6:0] == 7'b0010011) && (inst[14:12] == 3'b000) && (rd != 0), i.e. ADDI only.
  - On the rising edge with write enable, x[rd] <= sum.
  - All other encodings: no architectural write. Outputs still driven.
- Reset asserted mid-run:
  - pc and registers clear immediately.
  - Any write on the same edge as reset is discarded.
- No X propagation: every output is deterministic once rst_n has been asserted.

Decomposition:
- Shared package rv_pkg:
  - OPC_OP_IMM = 7'b0010011 and F3_ADDI = 3'b000.
  - Register index width (5) and XLEN.
  - Default RESET_PC.
- One natural sub-module: rv_regfile, 32x32, 2R/1W, x0 hardwired to zero, async active-low clear.
- PC, decode and adder stay inline in the top.

Test Plan:
- Reset, then hold rst_n high for 3 cycles -> pc = 0x80000000, 0x80000004, 0x80000008, 0x8000000C.
- inst = 0xFFD00193 (addi x3,x0,-3) -> rd = 3, imm = 0xFFFFFFFD, src1 = 0, sum = 0xFFFFFFFD. Next cycle inst = 0x00518213 (addi x4,x3,5) -> src1 = 0xFFFFFFFD, imm = 5, sum = 0x00000002.
- inst = 0x00500013 (addi x0,x0,5) -> sum = 5. Next cycle inst = 0x00000093 -> src1 = 0 (x0 unchanged).
- Non-ADDI write check:
  - inst = 0x000002B3 (add x5,x0,x0) with prior x5 = 0 -> rd = 5, no write.
  - Write x5 = 7 via 0x00700293, then apply 0x000002B3, then 0x00028313 -> src1 = 7 (not clobbered).
- RESET_PC = 0xFFFFFFF8, run 3 cycles -> pc = 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Mid-run reset:
  - Write x3 = 0xFFFFFFFD, then pulse rst_n low between edges -> pc = RESET_PC immediately.
  - After release, inst = 0x00018213 -> src1 = 0.
